// File: rtl/bitlet_bit_scanner_if.sv
// Handshake bundle for the bit scanner: a word stream in, a stream of
// set-bit position beats out.
interface bitlet_bit_scanner_if #(
   parameter int W     = 64,
   parameter int LANES = 2,
   parameter int TAG_W = 8
);
   localparam int CW = $clog2(W);

   logic                  in_valid;
   logic                  in_ready;
   logic [W-1:0]          in_data;
   logic [TAG_W-1:0]      in_tag;
   logic                  out_valid;
   logic                  out_ready;
   logic [LANES*CW-1:0]   out_pos;
   logic [LANES-1:0]      out_mask;
   logic                  out_first;
   logic                  out_last;
   logic                  out_zero;
   logic [TAG_W-1:0]      out_tag;

   // master: the surrounding pipeline (word producer and beat consumer)
   modport master (
      output in_valid, in_data, in_tag, out_ready,
      input  in_ready, out_valid, out_pos, out_mask, out_first, out_last,
             out_zero, out_tag
   );

   modport slave (
      input  in_valid, in_data, in_tag, out_ready,
      output in_ready, out_valid, out_pos, out_mask, out_first, out_last,
             out_zero, out_tag
   );
endinterface

// File: rtl/bitlet_bit_scanner.sv
// Sequential essential-bit extractor: emits the set-bit positions of each word
// MSB-first, up to LANES per beat, clearing emitted bits from a residual.
module bitlet_bit_scanner #(
   parameter int W     = 64,
   parameter int LANES = 2,
   parameter int TAG_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bitlet_bit_scanner_if.slave  bus
);
   localparam int CW = $clog2(W);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t                  state_reg;
   logic [W-1:0]            residual_reg;
   logic [TAG_W-1:0]        tag_reg;
   logic                    first_reg;
   logic                    zero_reg;

   logic [W-1:0]            remain_vec;
   logic [LANES-1:0][CW-1:0] lane_pos;
   logic [LANES-1:0]        lane_hit;
   logic                    busy;
   logic                    beat_last;
   logic                    fire_in;
   logic                    fire_out;

   // Each lane peels the highest remaining bit; remain_vec is what is left
   // after this beat, so an empty remainder means this is the last beat.
   always_comb begin
      remain_vec = residual_reg;
      lane_pos   = '0;
      lane_hit   = '0;
      for (int k = 0; k < LANES; k++) begin
         for (int b = 0; b < W; b++) begin
            if (remain_vec[b]) begin
               lane_pos[k] = b[CW-1:0];
               lane_hit[k] = 1'b1;
            end
         end
         if (lane_hit[k]) begin
            remain_vec[lane_pos[k]] = 1'b0;
         end
      end
   end

   assign busy      = (state_reg == SCAN);
   assign beat_last = busy & (remain_vec == '0);
   assign fire_out  = busy & bus.out_ready;
   assign fire_in   = bus.in_valid & bus.in_ready;

   assign bus.in_ready  = !busy | (fire_out & beat_last);
   assign bus.out_valid = busy;
   assign bus.out_mask  = lane_hit;
   assign bus.out_first = first_reg;
   assign bus.out_last  = beat_last;
   assign bus.out_zero  = zero_reg;
   assign bus.out_tag   = tag_reg;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign bus.out_pos[gi*CW +: CW] = lane_pos[gi];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         residual_reg <= '0;
         tag_reg      <= '0;
         first_reg    <= 1'b0;
         zero_reg     <= 1'b0;
      end else if (fire_in) begin
         // Also covers the back-to-back case where the last beat fires now.
         state_reg    <= SCAN;
         residual_reg <= bus.in_data;
         tag_reg      <= bus.in_tag;
         first_reg    <= 1'b1;
         zero_reg     <= (bus.in_data == '0);
      end else if (fire_out) begin
         if (beat_last) begin
            state_reg    <= IDLE;
            residual_reg <= '0;
            first_reg    <= 1'b0;
            zero_reg     <= 1'b0;
         end else begin
            residual_reg <= remain_vec;
            first_reg    <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_bitlet_bit_scanner.sv
// Bench for bitlet_bit_scanner: directed spec scenarios plus random traffic,
// checked cycle by cycle against a queue of expected beats.
module tb_bitlet_bit_scanner;
   localparam int W     = 64;
   localparam int LANES = 2;
   localparam int TAG_W = 8;
   localparam int CW    = 6;

   typedef struct packed {
      logic [LANES*CW-1:0] pos;
      logic [LANES-1:0]    mask;
      logic                first;
      logic                last;
      logic                zero;
      logic [TAG_W-1:0]    tag;
   } beat_t;

   logic  clk = 1'b0;
   logic  rst_n = 1'b0;
   int    checks = 0;
   int    passes = 0;
   int    fails  = 0;
   beat_t exp_q[$];

   bitlet_bit_scanner_if #(.W(W), .LANES(LANES), .TAG_W(TAG_W)) bus ();

   bitlet_bit_scanner #(.W(W), .LANES(LANES), .TAG_W(TAG_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected beats from the word: list set bits high to low, chunk by LANES.
   function automatic void model_word(input logic [63:0] d, input logic [7:0] t);
      int    p[$];
      beat_t bt;
      for (int b = W - 1; b >= 0; b--) if (d[b]) p.push_back(b);
      if (p.size() == 0) begin
         bt = '0;
         bt.first = 1'b1;
         bt.last  = 1'b1;
         bt.zero  = 1'b1;
         bt.tag   = t;
         exp_q.push_back(bt);
         return;
      end
      for (int i = 0; i < p.size(); i += LANES) begin
         bt = '0;
         bt.first = (i == 0);
         bt.last  = (i + LANES >= p.size());
         bt.tag   = t;
         for (int k = 0; k < LANES; k++) begin
            if (i + k < p.size()) begin
               bt.pos[k*CW +: CW] = 6'(p[i+k]);
               bt.mask[k] = 1'b1;
            end
         end
         exp_q.push_back(bt);
      end
   endfunction

   task automatic check_outputs();
      if (exp_q.size() == 0) begin
         chk("out_valid_idle", 64'(bus.out_valid), 64'd0);
      end else begin
         chk("out_valid", 64'(bus.out_valid), 64'd1);
         chk("out_pos",   64'(bus.out_pos),   64'(exp_q[0].pos));
         chk("out_mask",  64'(bus.out_mask),  64'(exp_q[0].mask));
         chk("out_first", 64'(bus.out_first), 64'(exp_q[0].first));
         chk("out_last",  64'(bus.out_last),  64'(exp_q[0].last));
         chk("out_zero",  64'(bus.out_zero),  64'(exp_q[0].zero));
         chk("out_tag",   64'(bus.out_tag),   64'(exp_q[0].tag));
      end
   endtask

   // One clock cycle, entered and left at posedge+1.
   task automatic cycle(input logic iv, input logic [63:0] d, input logic [7:0] t,
                        input logic ordy, output logic fired);
      logic exp_rdy;
      logic fire_out;
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.in_tag    = t;
      bus.out_ready = ordy;
      #1;
      exp_rdy  = (exp_q.size() == 0) || (ordy && exp_q[0].last);
      chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      fired    = iv && exp_rdy;
      fire_out = ordy && (exp_q.size() > 0);
      @(posedge clk);
      #1;
      if (fire_out) void'(exp_q.pop_front());
      if (fired) model_word(d, t);
      check_outputs();
   endtask

   task automatic send(input logic [63:0] d, input logic [7:0] t);
      logic fired = 1'b0;
      for (int n = 0; n < 200 && !fired; n++) cycle(1'b1, d, t, 1'b1, fired);
      if (!fired) chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      logic fired;
      for (int n = 0; n < 200 && exp_q.size() > 0; n++)
         cycle(1'b0, {$urandom, $urandom}, 8'($urandom), 1'b1, fired);
      if (exp_q.size() > 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic        fired;
      logic [63:0] d;
      int          mode;

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;

      #2;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst_out_pos",   64'(bus.out_pos),   64'd0);
      chk("rst_out_mask",  64'(bus.out_mask),  64'd0);
      chk("rst_out_first", 64'(bus.out_first), 64'd0);
      chk("rst_out_last",  64'(bus.out_last),  64'd0);
      chk("rst_out_zero",  64'(bus.out_zero),  64'd0);
      chk("rst_out_tag",   64'(bus.out_tag),   64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Spec scenarios 1-4
      send(64'h8000_0000_0000_0001, 8'h01);
      chk("t1_pos", 64'(bus.out_pos), {52'd0, 6'd0, 6'd63});
      drain();
      send(64'hF0, 8'h02);
      drain();
      send(64'h0, 8'h5A);
      chk("t3_zero", 64'(bus.out_zero), 64'd1);
      drain();
      send(64'h15, 8'h04);
      drain();

      // Scenario 5: stall three cycles mid-word, then stream the next word
      send(64'hF0, 8'h11);
      for (int n = 0; n < 3; n++) cycle(1'b0, {$urandom, $urandom}, 8'hEE, 1'b0, fired);
      cycle(1'b0, '0, 8'h00, 1'b1, fired);
      cycle(1'b1, 64'h15, 8'h22, 1'b1, fired);
      chk("t5_streamed", 64'(fired), 64'd1);
      chk("t5_no_bubble_first", 64'(bus.out_first), 64'd1);
      drain();

      // Scenario 6: asynchronous reset in the middle of a scan
      send(64'hFFFF, 8'h33);
      cycle(1'b0, '0, 8'h00, 1'b1, fired);
      cycle(1'b0, '0, 8'h00, 1'b1, fired);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 64'(bus.out_valid), 64'd0);
      chk("t6_async_mask",  64'(bus.out_mask),  64'd0);
      chk("t6_async_tag",   64'(bus.out_tag),   64'd0);
      chk("t6_async_ready", 64'(bus.in_ready),  64'd1);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int n = 0; n < 3; n++) cycle(1'b0, {$urandom, $urandom}, 8'h00, 1'b1, fired);

      // Random traffic with random backpressure and idle gaps
      for (int n = 0; n < 800; n++) begin
         mode = $urandom_range(3, 0);
         case (mode)
            0:       d = 64'd0;
            1:       d = {$urandom, $urandom};
            2:       d = 64'd1 << $urandom_range(63, 0);
            default: d = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         endcase
         cycle(($urandom % 4) != 0, d, 8'($urandom), ($urandom % 4) != 0, fired);
      end
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
